vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 91 +++++++++
 tb/tb_vram_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port frame-buffer arbiter; scan-out reads preempt a 4-deep write FIFO.
// Optional power-up clear of all 8192 words is enabled by defining VRAM_CLEAR_EN.
module vram_arbiter (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic [12:0] rd_addr,
    output logic [11:0] rd_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [12:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [11:0] ram_din,
    input  logic [11:0] ram_dout,
    output logic [2:0]  fifo_level,
    output logic        busy
);
    logic [12:0] q_addr [4];
    logic [11:0] q_data [4];
    logic [1:0]  rp;
    logic [1:0]  wp;
    logic        push;
    logic        pop;

`ifdef VRAM_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t      state;
    logic [12:0] clr_cnt;

    // Clear sweep: one zero write per cycle from address 0, then RUN until the next reset
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 13'd1;
            if (clr_cnt == 13'h1FFF) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end
    end
`else
    assign busy = 1'b0;
`endif

    assign rd_data  = ram_dout;
    assign wr_ready = (fifo_level < 3'd4) && !busy && rst_n;
    assign push     = wr_valid && wr_ready;
    assign pop      = !rd_req && !busy && (fifo_level != 3'd0);

    // RAM port mux: clear sweep, else scan-out, else FIFO head; writes are suppressed while in reset
    always_comb begin
        ram_addr = pop ? q_addr[rp] : rd_addr;
        ram_din  = pop ? q_data[rp] : 12'h000;
        ram_we   = pop && rst_n;
`ifdef VRAM_CLEAR_EN
        if (busy) begin
            ram_addr = clr_cnt;
            ram_din  = 12'h000;
            ram_we   = rst_n;
        end
`endif
    end

    // FIFO pointers and occupancy; push and pop together leave the level unchanged
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            rp         <= '0;
            wp         <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wp <= wp + 2'd1;
            if (pop)
                rp <= rp + 2'd1;
            fifo_level <= fifo_level + {2'b00, push} - {2'b00, pop};
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge pclk) begin
        if (push) begin
            q_addr[wp] <= wr_addr;
            q_data[wp] <= wr_data;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table, reset/clear sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_vram_arbiter;
    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [12:0] rd_addr = '0;
    logic        wr_valid = 1'b0;
    logic [12:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [11:0] rd_data;
    logic        wr_ready;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [11:0] ram_din;
    logic [11:0] ram_dout;
    logic [2:0]  fifo_level;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    logic [11:0] ram [8192];
    logic [11:0] shadow [8192];

    typedef struct {
        logic        rd;
        logic [12:0] ra;
        logic        wv;
        logic [12:0] wa;
        logic [11:0] wd;
        logic        we;
        logic [12:0] a;
        logic [11:0] din;
        logic        rdy;
        logic [2:0]  lvl;
        logic        crd;
        logic [11:0] rdd;
    } vec_t;

    typedef struct {
        logic [12:0] a;
        logic [11:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];

    always #20 pclk = ~pclk;

    vram_arbiter dut (
        .pclk(pclk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .fifo_level(fifo_level), .busy(busy)
    );

    // Single-port RAM with registered read (read-before-write)
    always @(posedge pclk) begin
        ram_dout <= ram[ram_addr];
        if (ram_we)
            ram[ram_addr] = ram_din;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        logic        exp_we;
        logic        exp_rdy;
        logic        prv_rd;
        logic [12:0] prv_a;
        logic [12:0] exp_a;
        int          rd_pct;

        for (int i = 0; i < 8192; i++) begin
            ram[i] = 12'(i) ^ 12'h5A5;
`ifdef VRAM_CLEAR_EN
            shadow[i] = 12'h000;
`else
            shadow[i] = 12'(i) ^ 12'h5A5;
`endif
        end

        // reset state
        repeat (3) tick();
        @(negedge pclk);
        chk("reset_level", 32'(fifo_level), 32'd0);
        chk("reset_we", 32'(ram_we), 32'd0);
        chk("reset_ready", 32'(wr_ready), 32'd0);
        tick();
        rst_n = 1'b1;
`ifdef VRAM_CLEAR_EN
        for (int i = 0; i < 8192; i++) begin
            @(negedge pclk);
            chk("clear_sweep", {17'd0, busy, ram_we, ram_addr, ram_din}, {17'd0, 1'b1, 1'b1, 13'(i), 12'h000});
            tick();
        end
`endif
        @(negedge pclk);
        chk("run_busy", 32'(busy), 32'd0);
        chk("run_ready", 32'(wr_ready), 32'd1);
        tick();

        ram[13'h100] = 12'hABC;

        //           rd  ra      wv  wa      wd       we  a       din      rdy lvl   crd rdd
        tbl.push_back('{0, 13'h010, 1, 13'h0A5, 12'hF00, 0, 13'h010, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{0, 13'h011, 0, 13'h000, 12'h000, 1, 13'h0A5, 12'hF00, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{1, 13'h020, 1, 13'h001, 12'h111, 0, 13'h020, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{1, 13'h021, 1, 13'h002, 12'h222, 0, 13'h021, 12'h000, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{1, 13'h022, 1, 13'h003, 12'h333, 0, 13'h022, 12'h000, 1, 3'd2, 0, 12'h000});
        tbl.push_back('{1, 13'h023, 1, 13'h004, 12'h444, 0, 13'h023, 12'h000, 1, 3'd3, 0, 12'h000});
        tbl.push_back('{1, 13'h024, 1, 13'h005, 12'h555, 0, 13'h024, 12'h000, 0, 3'd4, 0, 12'h000});
        tbl.push_back('{0, 13'h025, 0, 13'h000, 12'h000, 1, 13'h001, 12'h111, 0, 3'd4, 0, 12'h000});
        tbl.push_back('{0, 13'h025, 0, 13'h000, 12'h000, 1, 13'h002, 12'h222, 1, 3'd3, 0, 12'h000});
        tbl.push_back('{0, 13'h025, 0, 13'h000, 12'h000, 1, 13'h003, 12'h333, 1, 3'd2, 0, 12'h000});
        tbl.push_back('{0, 13'h025, 0, 13'h000, 12'h000, 1, 13'h004, 12'h444, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{0, 13'h026, 0, 13'h000, 12'h000, 0, 13'h026, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{1, 13'h030, 1, 13'h010, 12'hAAA, 0, 13'h030, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{1, 13'h031, 1, 13'h011, 12'hBBB, 0, 13'h031, 12'h000, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{0, 13'h032, 1, 13'h012, 12'hCCC, 1, 13'h010, 12'hAAA, 1, 3'd2, 0, 12'h000});
        tbl.push_back('{0, 13'h032, 0, 13'h000, 12'h000, 1, 13'h011, 12'hBBB, 1, 3'd2, 0, 12'h000});
        tbl.push_back('{0, 13'h032, 0, 13'h000, 12'h000, 1, 13'h012, 12'hCCC, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{0, 13'h033, 0, 13'h000, 12'h000, 0, 13'h033, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{1, 13'h034, 1, 13'h040, 12'h001, 0, 13'h034, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{1, 13'h035, 1, 13'h040, 12'h002, 0, 13'h035, 12'h000, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{0, 13'h036, 0, 13'h000, 12'h000, 1, 13'h040, 12'h001, 1, 3'd2, 0, 12'h000});
        tbl.push_back('{0, 13'h036, 0, 13'h000, 12'h000, 1, 13'h040, 12'h002, 1, 3'd1, 0, 12'h000});
        tbl.push_back('{1, 13'h040, 0, 13'h000, 12'h000, 0, 13'h040, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{1, 13'h041, 0, 13'h000, 12'h000, 0, 13'h041, 12'h000, 1, 3'd0, 1, 12'h002});
        tbl.push_back('{1, 13'h100, 0, 13'h000, 12'h000, 0, 13'h100, 12'h000, 1, 3'd0, 0, 12'h000});
        tbl.push_back('{0, 13'h000, 0, 13'h000, 12'h000, 0, 13'h000, 12'h000, 1, 3'd0, 1, 12'hABC});

        foreach (tbl[i]) begin
            rd_req   = tbl[i].rd;
            rd_addr  = tbl[i].ra;
            wr_valid = tbl[i].wv;
            wr_addr  = tbl[i].wa;
            wr_data  = tbl[i].wd;
            @(negedge pclk);
            chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(tbl[i].we));
            chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(tbl[i].a));
            chk($sformatf("vec%0d_ready", i), 32'(wr_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
            if (tbl[i].we)
                chk($sformatf("vec%0d_din", i), 32'(ram_din), 32'(tbl[i].din));
            if (tbl[i].crd)
                chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].rdd));
            tick();
        end

        // reset with three writes queued behind a held read
        rd_req = 1'b1;
        rd_addr = 13'h060;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 13'h050 + 13'(i);
            wr_data = 12'hE01 + 12'(i);
            tick();
        end
        wr_valid = 1'b0;
        @(negedge pclk);
        chk("rst_pre_level", 32'(fifo_level), 32'd3);
        tick();
        rst_n = 1'b0;
        rd_req = 1'b0;
        @(negedge pclk);
        chk("rst_in_we", 32'(ram_we), 32'd0);
        chk("rst_in_ready", 32'(wr_ready), 32'd0);
        tick();
        @(negedge pclk);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        tick();
        rst_n = 1'b1;
`ifdef VRAM_CLEAR_EN
        for (int i = 0; i < 9000 && busy !== 1'b0; i++)
            tick();
        chk("reclear_done", 32'(busy), 32'd0);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk("rst_no_commit", 32'(ram_we), 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++)
            chk("rst_ram_kept", 32'(ram[13'h050 + 13'(i)]), 32'(shadow[13'h050 + 13'(i)]));

        // random traffic against a queue model in an address window untouched above
        prv_rd = 1'b0;
        prv_a = '0;
        for (int c = 0; c < 2000; c++) begin
            rd_pct = ((c / 150) % 2 == 1) ? 85 : 30;
            rd_req   = ($urandom_range(0, 99) < rd_pct);
            rd_addr  = 13'h1000 + 13'($urandom_range(0, 31));
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = 13'h1000 + 13'($urandom_range(0, 31));
            wr_data  = 12'($urandom);
            @(negedge pclk);
            exp_we  = !rd_req && q.size() > 0;
            exp_rdy = q.size() < 4;
            exp_a   = exp_we ? q[0].a : rd_addr;
            chk("rnd_we", 32'(ram_we), 32'(exp_we));
            chk("rnd_ready", 32'(wr_ready), 32'(exp_rdy));
            chk("rnd_level", 32'(fifo_level), 32'(q.size()));
            chk("rnd_addr", 32'(ram_addr), 32'(exp_a));
            if (exp_we)
                chk("rnd_din", 32'(ram_din), 32'(q[0].d));
            if (prv_rd)
                chk("rnd_rd_data", 32'(rd_data), 32'(shadow[prv_a]));
            @(posedge pclk);
            if (exp_we) begin
                shadow[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (wr_valid && exp_rdy)
                q.push_back('{wr_addr, wr_data});
            prv_rd = rd_req;
            prv_a = rd_addr;
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
